// File: rtl/sample_tick_gen.sv
// Sample-clock generator: square wave with rise/fall strobes, glitch-free
// runtime divisor reload and single-cycle phase advance/retard.
module sample_tick_gen #(
    parameter int unsigned CNT_W        = 22,
    parameter int unsigned DEFAULT_HALF = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_half,
    input  logic             div_load,
    input  logic             adv,
    input  logic             ret,
    output logic             new_clock,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             adj_busy
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half_act, half_act_n;
    logic [CNT_W-1:0] half_shd, half_shd_n;
    logic             load_pend, load_pend_n;
    logic             pend_adv, pend_adv_n;
    logic             pend_ret, pend_ret_n;
    logic             new_clock_n, rise_n, fall_n;

    logic hit_term, adv_hit, do_retard, do_toggle;

    always_comb begin
        hit_term  = (cnt == half_act);
        adv_hit   = pend_adv && (half_act != '0) && (cnt == half_act - CNT_W'(1));
        do_retard = en && pend_ret && hit_term;
        do_toggle = en && !do_retard && (hit_term || adv_hit);

        cnt_n       = cnt;
        half_act_n  = half_act;
        half_shd_n  = half_shd;
        load_pend_n = load_pend;
        pend_adv_n  = pend_adv;
        pend_ret_n  = pend_ret;
        new_clock_n = new_clock;
        rise_n      = 1'b0;
        fall_n      = 1'b0;

        if (div_load)
            half_shd_n = div_half;

        if (do_toggle) begin
            new_clock_n = ~new_clock;
            rise_n      = ~new_clock;
            fall_n      = new_clock;
            cnt_n       = '0;
            // An advance that cannot shorten a zero-length half is discarded here.
            if (adv_hit || half_act == '0)
                pend_adv_n = 1'b0;
            if (load_pend)
                half_act_n = half_shd;
            load_pend_n = 1'b0;
        end else if (do_retard) begin
            pend_ret_n = 1'b0;
        end else if (en) begin
            cnt_n = cnt + CNT_W'(1);
        end

        // Loads and requests arriving with a toggle apply to the following half.
        if (div_load)
            load_pend_n = 1'b1;

        if (adv && !ret) begin
            if (pend_ret_n)
                pend_ret_n = 1'b0;
            else
                pend_adv_n = 1'b1;
        end else if (ret && !adv) begin
            if (pend_adv_n)
                pend_adv_n = 1'b0;
            else
                pend_ret_n = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt       <= '0;
            half_act  <= HALF_RST;
            half_shd  <= HALF_RST;
            load_pend <= 1'b0;
            pend_adv  <= 1'b0;
            pend_ret  <= 1'b0;
            new_clock <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            half_act  <= half_act_n;
            half_shd  <= half_shd_n;
            load_pend <= load_pend_n;
            pend_adv  <= pend_adv_n;
            pend_ret  <= pend_ret_n;
            new_clock <= new_clock_n;
            rise_tick <= rise_n;
            fall_tick <= fall_n;
        end
    end

    assign adj_busy = pend_adv | pend_ret;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Directed bench for sample_tick_gen: half-period lengths measured in cycles
// between strobes and compared against hand-derived values.
module tb_sample_tick_gen;

    localparam int unsigned CNT_W = 22;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] div_half = '0;
    logic             div_load = 1'b0;
    logic             adv = 1'b0;
    logic             ret = 1'b0;
    logic             new_clock, rise_tick, fall_tick, adj_busy;

    int tests = 0;
    int fails = 0;

    sample_tick_gen #(.CNT_W(CNT_W), .DEFAULT_HALF(6)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .div_half  (div_half),
        .div_load  (div_load),
        .adv       (adv),
        .ret       (ret),
        .new_clock (new_clock),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .adj_busy  (adj_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        do begin tick(); n++; end while (!rise_tick && n < 50);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin tick(); n++; end while (!fall_tick && n < 50);
    endtask

    task automatic load(input int v);
        div_half = CNT_W'(v);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0; en = 1'b1;
        repeat (3) tick();
        tests++;
        if ({new_clock, rise_tick, fall_tick, adj_busy} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs: got %b, expected 0000", {new_clock, rise_tick, fall_tick, adj_busy});
        end
        reset_n = 1'b1;
        wait_rise(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL first_rise: got %0d cycles, expected 7", n); end
        tests++;
        if (new_clock !== 1'b1) begin fails++; $display("FAIL clk_high_at_rise: got %b, expected 1", new_clock); end
        tick();
        tests++;
        if ({rise_tick, fall_tick, new_clock} !== 3'b001) begin
            fails++; $display("FAIL tick_width: got %b, expected 001", {rise_tick, fall_tick, new_clock});
        end
        wait_fall(n);
        tests++;
        if (n !== 6) begin fails++; $display("FAIL default_high: got %0d cycles, expected 6 after strobe cycle", n); end
        wait_rise(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL default_low: got %0d cycles, expected 7", n); end
    endtask

    task automatic test_div_load();
        int n;
        bit ok;
        // At a rise: load 2 after 3 cycles into the high phase.
        repeat (3) tick();
        load(2);
        wait_fall(n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL load_no_truncate: got %0d, expected 3 (7 total)", n); end
        wait_rise(n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL load_low3: got %0d, expected 3", n); end
        wait_fall(n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL load_high3: got %0d, expected 3", n); end
        load(0);
        wait_rise(n);
        tests++;
        if (n !== 2) begin fails++; $display("FAIL load0_last3: got %0d, expected 2", n); end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (new_clock !== ((i % 2) == 1) || rise_tick !== ((i % 2) == 1) || fall_tick !== ((i % 2) == 0))
                ok = 1'b0;
        end
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL div0_toggle_every_cycle: got %b, expected 1", ok); end
        load(6);
        tick();
        wait_rise(n);
    endtask

    task automatic test_adv_ret();
        int n;
        wait_fall(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL baseline_high: got %0d, expected 7", n); end
        adv = 1'b1; tick(); adv = 1'b0;
        tests++;
        if (adj_busy !== 1'b1) begin fails++; $display("FAIL adv_busy: got %b, expected 1", adj_busy); end
        wait_rise(n);
        tests++;
        if (n !== 5) begin fails++; $display("FAIL adv_half: got %0d, expected 5 (6 total)", n); end
        tests++;
        if (adj_busy !== 1'b0) begin fails++; $display("FAIL adv_busy_clear: got %b, expected 0", adj_busy); end
        wait_fall(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL after_adv: got %0d, expected 7", n); end
        ret = 1'b1; tick(); ret = 1'b0;
        tests++;
        if (adj_busy !== 1'b1) begin fails++; $display("FAIL ret_busy: got %b, expected 1", adj_busy); end
        wait_rise(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL ret_half: got %0d, expected 7 (8 total)", n); end
        tests++;
        if (adj_busy !== 1'b0) begin fails++; $display("FAIL ret_busy_clear: got %b, expected 0", adj_busy); end
        wait_fall(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL after_ret: got %0d, expected 7", n); end
    endtask

    task automatic test_simul_cancel();
        int n;
        adv = 1'b1; ret = 1'b1; tick(); adv = 1'b0; ret = 1'b0;
        tests++;
        if (adj_busy !== 1'b0) begin fails++; $display("FAIL simul_busy: got %b, expected 0", adj_busy); end
        wait_rise(n);
        tests++;
        if (n !== 6) begin fails++; $display("FAIL simul_half: got %0d, expected 6 (7 total)", n); end
        ret = 1'b1; tick(); ret = 1'b0;
        adv = 1'b1; tick(); adv = 1'b0;
        tests++;
        if (adj_busy !== 1'b0) begin fails++; $display("FAIL cancel_busy: got %b, expected 0", adj_busy); end
        wait_fall(n);
        tests++;
        if (n !== 5) begin fails++; $display("FAIL cancel_half: got %0d, expected 5 (7 total)", n); end
        // half_act = 0, then an advance that must be dropped.
        load(0);
        wait_rise(n);
        adv = 1'b1; tick(); adv = 1'b0;
        tests++;
        if (new_clock !== 1'b0) begin fails++; $display("FAIL adv0_toggle: got %b, expected 0", new_clock); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (new_clock !== ((i % 2) == 0)) begin
                fails++; $display("FAIL adv0_period step %0d: got %b, expected %b", i, new_clock, (i % 2) == 0);
            end
        end
        tests++;
        if (adj_busy !== 1'b0) begin fails++; $display("FAIL adv0_dropped: got %b, expected 0", adj_busy); end
        load(6);
        tick();
        wait_rise(n);
    endtask

    task automatic test_enable();
        int n;
        bit ok;
        repeat (3) tick();
        en = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin div_half = CNT_W'(3); div_load = 1'b1; end
            tick();
            div_load = 1'b0;
            if (new_clock !== 1'b1 || rise_tick !== 1'b0 || fall_tick !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL en_hold: got %b, expected 1", ok); end
        en = 1'b1;
        wait_fall(n);
        tests++;
        if (n !== 4) begin fails++; $display("FAIL en_resume: got %0d, expected 4 (7 counted)", n); end
        wait_rise(n);
        tests++;
        if (n !== 4) begin fails++; $display("FAIL en_newdiv_low: got %0d, expected 4", n); end
        wait_fall(n);
        tests++;
        if (n !== 4) begin fails++; $display("FAIL en_newdiv_high: got %0d, expected 4", n); end
        load(6);
        wait_rise(n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL restore_last4: got %0d, expected 3", n); end
        wait_fall(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL restore_high: got %0d, expected 7", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_rise(n);
        tick();
        adv = 1'b1; tick(); adv = 1'b0;
        tests++;
        if ({new_clock, adj_busy} !== 2'b11) begin
            fails++; $display("FAIL mid_pre: got %b, expected 11", {new_clock, adj_busy});
        end
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        tests++;
        if ({new_clock, adj_busy, rise_tick, fall_tick} !== 4'b0000) begin
            fails++; $display("FAIL mid_reset: got %b, expected 0000", {new_clock, adj_busy, rise_tick, fall_tick});
        end
        wait_rise(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL mid_restart_rise: got %0d, expected 7", n); end
        wait_fall(n);
        tests++;
        if (n !== 7) begin fails++; $display("FAIL mid_restart_high: got %0d, expected 7", n); end
    endtask

    initial begin
        test_reset();
        test_div_load();
        test_adv_ret();
        test_simul_cancel();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
